mem_port_unit: RTL and testbench

Memory-port sequencer between the multicycle controller and the external unified instruction/data memory. It turns the controller's per-state memory strobes into a registered request/acknowledge transaction and selects the address as PC or ALUOut. It captures read data into the instruction register or the memory data register. Its `Busy` output stalls the controller's state advance until the access completes.

---
 rtl/mem_port_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_port_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_unit.sv
// Memory-port sequencer: turns the multicycle controller's memory strobes into a
// registered req/ack access (address PC or ALUOut) and captures read data into Instr/MDR.
// Latency: mem_req one cycle after start; Busy holds the controller until the ack cycle.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access after TO_CYCLES wait
// cycles without ack and set the sticky BusErr flag. Undefined: BusErr is tied to 0.
//
// Ports:
//   Clk, Reset          clock (rising edge), asynchronous active-low reset
//   PC, ALUOut, B       fetch address, data address, store data
//   lorD                address select (0: PC, 1: ALUOut)
//   IRWrite/MemRead/MemWrite  access strobes (fetch > write > read priority)
//   Busy                stall to the controller
//   Instr, MDR          captured instruction / memory data registers
//   BusErr              sticky timeout flag
//   mem_req/mem_we/mem_addr/mem_wdata  registered request to memory
//   mem_rdata/mem_ack   memory response
module mem_port_unit #(
  parameter int DATA_W    = 32,
  parameter int TO_CYCLES = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] B,
  input  logic              lorD,
  input  logic              IRWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic              Busy,
  output logic [DATA_W-1:0] Instr,
  output logic [DATA_W-1:0] MDR,
  output logic              BusErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_READ  = 2'd1;
  localparam logic [1:0] K_WRITE = 2'd2;

  logic              state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        kind_q, kind_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;

  logic       start;
  logic [1:0] kind_sel;
  logic       to_hit;

  assign start    = IRWrite | MemRead | MemWrite;
  assign kind_sel = IRWrite ? K_FETCH : (MemWrite ? K_WRITE : K_READ);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buserr_q, buserr_d;

  // The abort cycle is the WAIT cycle whose missing ack would bring the count to
  // TO_CYCLES; an ack in that same cycle still completes normally.
  assign to_hit = (state_q == ST_WAIT) && !mem_ack &&
                  (cnt_q == CNT_W'(TO_CYCLES - 1));
  assign BusErr = buserr_q;

  always_comb begin
    cnt_d    = cnt_q;
    buserr_d = buserr_q;
    if (state_q == ST_IDLE) begin
      if (start) cnt_d = '0;
    end else if (!mem_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (to_hit) buserr_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q    <= '0;
      buserr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      buserr_q <= buserr_d;
    end
  end
`else
  assign to_hit = 1'b0;
  assign BusErr = 1'b0;
`endif

  // Busy drops in the ack (or abort) cycle so the controller advances on the
  // same edge that captures the read data.
  assign Busy = ((state_q == ST_IDLE) && start) ||
                ((state_q == ST_WAIT) && !mem_ack && !to_hit);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    mdr_d   = mdr_q;
    if (state_q == ST_IDLE) begin
      // mem_ack is deliberately ignored here: a late ack belongs to nothing.
      if (start) begin
        state_d = ST_WAIT;
        addr_d  = lorD ? ALUOut : PC;
        wdata_d = B;
        we_d    = (kind_sel == K_WRITE);
        kind_d  = kind_sel;
      end
    end else begin
      if (mem_ack) begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
        case (kind_q)
          K_FETCH: instr_d = mem_rdata;
          K_READ:  mdr_d   = mem_rdata;
          default: ;
        endcase
      end else if (to_hit) begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      kind_q  <= K_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      mdr_q   <= mdr_d;
    end
  end

  // The request is exactly "in WAIT", which is itself a register.
  assign mem_req   = (state_q == ST_WAIT);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign Instr     = instr_q;
  assign MDR       = mdr_q;

endmodule

// File: tb/tb_mem_port_unit.sv
// Randomized scoreboard bench for mem_port_unit.
// Driver issues controller strobes, responder plays the memory, monitor checks.
// Expected requests and captures come from a high-level access model.
module tb_mem_port_unit;

  localparam int TO = 15;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PC, ALUOut, B;
  logic        lorD, IRWrite, MemRead, MemWrite;
  logic        Busy, BusErr, mem_req, mem_we, mem_ack;
  logic [31:0] Instr, MDR, mem_addr, mem_wdata, mem_rdata;

  always #5 Clk = ~Clk;

  mem_port_unit #(.DATA_W(32), .TO_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .PC(PC), .ALUOut(ALUOut), .B(B), .lorD(lorD),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Busy(Busy),
    .Instr(Instr), .MDR(MDR), .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Access kinds in the bench's own terms.
  localparam int KF = 0, KR = 1, KW = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    int          busy;
  } exp_t;

  typedef struct {
    int          w;
    logic [31:0] rdata;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, expv, $time);
  endtask

  function automatic int ref_kind(input logic irw, input logic mw);
    if (irw) return KF;
    if (mw) return KW;
    return KR;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit          mon_en = 1'b0;
  bit          chk_regs = 1'b0;
  int          busy_cnt = 0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_mdr = 32'h0;
  exp_t        mon_e;

  always @(negedge Clk) begin
    if (mon_en && Reset) begin
      if (chk_regs) begin
        chk("instr_capture", Instr, m_instr);
        chk("mdr_capture", MDR, m_mdr);
        chk_regs = 1'b0;
      end
      if (Busy === 1'b1) busy_cnt++;
      if (mem_req === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_req: got mem_req=1 with no access outstanding at %0t", $time);
        end else begin
          mon_e = exp_q[0];
          chk("mem_addr", mem_addr, mon_e.addr);
          chk("mem_we", mem_we, mon_e.we);
          chk("mem_wdata", mem_wdata, mon_e.wdata);
          if (mem_ack === 1'b1) begin
            chk("busy_in_ack", Busy, 1'b0);
            chk("busy_cycles", busy_cnt, mon_e.busy);
            busy_cnt = 0;
            if (mon_e.kind == KF) m_instr = mon_e.rdata;
            if (mon_e.kind == KR) m_mdr = mon_e.rdata;
            chk_regs = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- memory responder ----------------
  bit          r_active = 1'b0;
  int          r_w = 0;
  logic [31:0] r_rd = 32'h0;
  plan_t       r_p;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge Clk);
      #2;
      if (mem_req === 1'b1) begin
        if (!r_active) begin
          r_active = 1'b1;
          if (plan_q.size() > 0) begin
            r_p  = plan_q.pop_front();
            r_w  = r_p.w;
            r_rd = r_p.rdata;
          end else begin
            r_w = 1000000;
          end
        end
        if (r_w == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = r_rd;
          r_active  = 1'b0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          r_w--;
        end
      end else begin
        // Stray acks while idle must be ignored by the DUT.
        r_active  = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic launch(input logic [2:0] strb, input logic ld, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] b, input int w,
                        input logic [31:0] rd);
    exp_t  e;
    plan_t p;
    @(posedge Clk);
    #1;
    IRWrite  = strb[2];
    MemRead  = strb[1];
    MemWrite = strb[0];
    lorD     = ld;
    PC       = pc;
    ALUOut   = alu;
    B        = b;
    e.kind   = ref_kind(strb[2], strb[0]);
    e.addr   = ld ? alu : pc;
    e.wdata  = b;
    e.we     = (e.kind == KW);
    e.rdata  = rd;
    e.busy   = 1 + w;
    exp_q.push_back(e);
    p.w      = w;
    p.rdata  = rd;
    plan_q.push_back(p);
  endtask

  task automatic issue(input logic [2:0] strb, input logic ld, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] b, input int w,
                       input logic [31:0] rd);
    int k;
    launch(strb, ld, pc, alu, b, w, rd);
    @(posedge Clk);
    #1;
    // Operand buses move while waiting; the latched request must not.
    PC     = $urandom;
    ALUOut = $urandom;
    B      = $urandom;
    lorD   = 1'($urandom_range(0, 1));
    @(negedge Clk);
    chk("req_rise", mem_req, 1'b1);
    k = 0;
    while (Busy === 1'b1 && k < 50) begin
      @(negedge Clk);
      k++;
    end
    if (k >= 50) begin
      n_chk++;
      $display("FAIL busy_bound: Busy still 1 after %0d cycles, required 0", k);
    end
  endtask

  task automatic go_idle(input int n);
    @(posedge Clk);
    #1;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    repeat (n) @(posedge Clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, Busy, 1'b0);
    chk({tag, "_req"}, mem_req, 1'b0);
    chk({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_buserr"}, BusErr, 1'b0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_instr"}, Instr, 32'h0);
    chk({tag, "_mdr"}, MDR, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          rc;
    logic        last_busy;
    logic [2:0]  s;
    Reset = 1'b1; PC = 0; ALUOut = 0; B = 0; lorD = 0;
    IRWrite = 0; MemRead = 0; MemWrite = 0;
    #2 Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk_reset_state("rst");
    @(posedge Clk); #1 Reset = 1'b1;
    @(negedge Clk);
    chk_reset_state("rel");
    mon_en = 1'b1;

    // Directed: fetch with 3 wait cycles, zero-wait read, write then fetch back-to-back,
    // fetch+write collision resolved as fetch.
    issue(3'b100, 1'b0, 32'h40, 32'h0, 32'h0, 3, 32'h8C220004);
    go_idle(1);
    issue(3'b010, 1'b1, 32'h0, 32'h104, 32'h0, 0, 32'hDEADBEEF);
    go_idle(1);
    issue(3'b001, 1'b1, 32'h0, 32'h200, 32'h1234, 2, 32'h55555555);
    issue(3'b100, 1'b0, 32'h44, 32'h0, 32'h0, 1, 32'h01234567);
    go_idle(0);
    issue(3'b101, 1'b0, 32'h48, 32'h300, 32'hABCD, 1, 32'h0BADF00D);
    go_idle(2);

    // Randomized accesses, with random back-to-back and idle gaps.
    for (int i = 0; i < 60; i++) begin
      s = 3'($urandom_range(1, 7));
      issue(s, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
            $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 2) != 0) go_idle($urandom_range(0, 3));
    end
    go_idle(2);

    // Reset in the middle of a wait; the pending ack must be ignored afterwards.
    launch(3'b100, 1'b0, 32'h80, 32'h0, 32'h0, 6, 32'hFEEDFACE);
    @(posedge Clk); #1;
    IRWrite = 1'b0;
    @(posedge Clk); #1;
    mon_en = 1'b0;
    Reset  = 1'b0;
    #1;
    chk_reset_state("midrst");
    exp_q.delete();
    plan_q.delete();
    m_instr  = 32'h0;
    m_mdr    = 32'h0;
    busy_cnt = 0;
    chk_regs = 1'b0;
    @(posedge Clk); #1 Reset = 1'b1;
    repeat (8) @(negedge Clk);
    chk("postrst_req", mem_req, 1'b0);
    chk("postrst_instr", Instr, 32'h0);
    chk("postrst_mdr", MDR, 32'h0);
    mon_en = 1'b1;
    issue(3'b010, 1'b0, 32'h90, 32'h0, 32'h0, 2, 32'h13579BDF);
    go_idle(3);
    mon_en = 1'b0;

    // Access that is never acknowledged.
    launch(3'b100, 1'b0, 32'hC0, 32'h0, 32'h0, 1000000, 32'h0);
    exp_q.delete();
    @(posedge Clk); #1;
    IRWrite = 1'b0;
    rc = 0;
    last_busy = 1'b1;
`ifdef MEM_TIMEOUT_EN
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (mem_req === 1'b1) begin
        rc++;
        last_busy = Busy;
      end
    end
    chk("to_req_cycles", rc, TO);
    chk("to_busy_abort", last_busy, 1'b0);
    chk("to_buserr", BusErr, 1'b1);
    chk("to_busy_after", Busy, 1'b0);
    repeat (10) @(negedge Clk);
    chk("to_buserr_sticky", BusErr, 1'b1);
    chk("to_req_low", mem_req, 1'b0);
`else
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      if (mem_req === 1'b1) rc++;
      last_busy = Busy;
    end
    chk("hang_req_cycles", rc, 100);
    chk("hang_busy", last_busy, 1'b1);
    chk("hang_buserr", BusErr, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
